// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the program loader.
package prog_loader_pkg;

    localparam int unsigned LOADER_IW = 9;
    localparam int unsigned LOADER_AW = 16;
    localparam int unsigned RUN_CW    = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        FINISH,
        ERR
    } loader_state_t;

    // One instruction-memory write: address plus word.
    typedef struct packed {
        logic [LOADER_AW-1:0] addr;
        logic [LOADER_IW-1:0] data;
    } imem_wr_t;

    // A transfer in these states begins a fresh program at address 0.
    function automatic logic is_load_entry(input loader_state_t s);
        return (s == IDLE) || (s == FINISH);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host word stream and instruction-memory write port of the loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [LOADER_IW-1:0] in_data;
    logic                 in_last;
    logic                 imem_we;
    logic [LOADER_AW-1:0] imem_addr;
    logic [LOADER_IW-1:0] imem_wdata;

    // Loader side.
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    // Host / memory side.
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/prog_loader_sat_counter.sv
// Up-counter with enable, synchronous clear and saturation at LIMIT.
module prog_loader_sat_counter #(
    parameter int unsigned W     = 8,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear wins over enable; count stops at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, pulses START, then times the run.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS    = 1024,
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 1048576
) (
    input  logic                 CLK,
    input  logic                 reset,
    prog_loader_if.slave         bus,
    output logic                 proc_start,
    input  logic                 proc_done,
    output logic [LOADER_AW-1:0] load_count,
    output logic [RUN_CW-1:0]    run_cycles,
    output logic                 run_done,
    output logic                 error
);

    localparam int unsigned SW = $clog2(START_CYCLES + 2);

    localparam logic [LOADER_AW-1:0] MAX_CNT     = LOADER_AW'(MAX_WORDS);
    localparam logic [RUN_CW-1:0]    TIMEOUT_CNT = RUN_CW'(TIMEOUT);
    localparam logic [RUN_CW-1:0]    TIMEOUT_PRE = RUN_CW'(TIMEOUT - 1);
    localparam logic [SW-1:0]        START_CNT   = SW'(START_CYCLES);

    loader_state_t        state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 we_q, we_d;
    imem_wr_t             wr_q, wr_d;
    logic [LOADER_AW-1:0] lc_q, lc_d;
    logic                 run_done_q, run_done_d;
    logic                 error_q, error_d;
    logic                 proc_start_q, proc_start_d;

    logic                 xfer_c;
    logic                 run_clr_c;
    logic                 run_en_c;
    logic                 start_en_c;
    logic [LOADER_AW-1:0] idx_c;
    logic [LOADER_AW-1:0] cnt_new_c;
    logic [RUN_CW-1:0]    run_cnt;
    logic [SW-1:0]        start_cnt;

    assign xfer_c     = bus.in_valid & in_ready_q;
    assign run_en_c   = (state_q == RUN);
    assign start_en_c = (state_q == START);

    // RUN-cycle timer; frozen outside RUN, cleared when a new load begins.
    prog_loader_sat_counter #(
        .W     (RUN_CW),
        .LIMIT (TIMEOUT_CNT)
    ) u_run_cnt (
        .clk   (CLK),
        .rst_n (reset),
        .en_i  (run_en_c),
        .clr_i (run_clr_c),
        .cnt_o (run_cnt)
    );

    // Cycles spent in START; the first START cycle carries the final write.
    prog_loader_sat_counter #(
        .W     (SW),
        .LIMIT (START_CNT)
    ) u_start_cnt (
        .clk   (CLK),
        .rst_n (reset),
        .en_i  (start_en_c),
        .clr_i (!start_en_c),
        .cnt_o (start_cnt)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        we_d         = 1'b0;
        wr_d         = wr_q;
        lc_d         = lc_q;
        run_done_d   = run_done_q;
        error_d      = error_q;
        proc_start_d = 1'b0;
        run_clr_c    = 1'b0;
        idx_c        = is_load_entry(state_q) ? '0 : lc_q;
        cnt_new_c    = idx_c + LOADER_AW'(1);

        case (state_q)
            IDLE, LOAD, FINISH: begin
                in_ready_d = 1'b1;
                if (xfer_c) begin
                    we_d      = 1'b1;
                    wr_d.addr = idx_c;
                    wr_d.data = bus.in_data;
                    lc_d      = cnt_new_c;
                    if (is_load_entry(state_q)) begin
                        run_done_d = 1'b0;
                        run_clr_c  = 1'b1;
                    end
                    if (bus.in_last) begin
                        in_ready_d = 1'b0;
                        state_d    = START;
                    end else if (cnt_new_c == MAX_CNT) begin
                        in_ready_d = 1'b0;
                        error_d    = 1'b1;
                        state_d    = ERR;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            START: begin
                in_ready_d = 1'b0;
                if (start_cnt == START_CNT) begin
                    state_d = RUN;
                end else begin
                    proc_start_d = 1'b1;
                end
            end
            RUN: begin
                in_ready_d = 1'b0;
                if (proc_done) begin
                    run_done_d = 1'b1;
                    in_ready_d = 1'b1;
                    state_d    = FINISH;
                end else if (run_cnt == TIMEOUT_PRE) begin
                    error_d = 1'b1;
                    state_d = ERR;
                end
            end
            ERR: begin
                in_ready_d = 1'b0;
                error_d    = 1'b1;
            end
            default: begin
                in_ready_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            we_q         <= 1'b0;
            wr_q         <= '0;
            lc_q         <= '0;
            run_done_q   <= 1'b0;
            error_q      <= 1'b0;
            proc_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            we_q         <= we_d;
            wr_q         <= wr_d;
            lc_q         <= lc_d;
            run_done_q   <= run_done_d;
            error_q      <= error_d;
            proc_start_q <= proc_start_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = wr_q.addr;
    assign bus.imem_wdata = wr_q.data;
    assign proc_start     = proc_start_q;
    assign load_count     = lc_q;
    assign run_cycles     = run_cnt;
    assign run_done       = run_done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed table-driven bench for prog_loader (MAX_WORDS=4, TIMEOUT=8).
module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        reset;
    logic        proc_done;
    logic        proc_start;
    logic [15:0] load_count;
    logic [31:0] run_cycles;
    logic        run_done;
    logic        error;

    prog_loader_if bus();

    prog_loader #(
        .MAX_WORDS    (4),
        .START_CYCLES (2),
        .TIMEOUT      (8)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .bus        (bus),
        .proc_start (proc_start),
        .proc_done  (proc_done),
        .load_count (load_count),
        .run_cycles (run_cycles),
        .run_done   (run_done),
        .error      (error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        v;
        logic [8:0]  d;
        logic        l;
        logic        done;
        logic        rdy;
        logic        we;
        logic [15:0] addr;
        logic [8:0]  wd;
        logic        ps;
        logic [15:0] lc;
        logic [31:0] rc;
        logic        rd;
        logic        err;
    } row_t;

    int checks = 0;
    int errors = 0;
    row_t tbl[$];
    row_t zero_row;

    function automatic row_t mk(input logic v, input logic [8:0] d, input logic l,
                                input logic done, input logic rdy, input logic we,
                                input logic [15:0] addr, input logic [8:0] wd,
                                input logic ps, input logic [15:0] lc,
                                input logic [31:0] rc, input logic rd, input logic err);
        row_t r;
        r.v = v; r.d = d; r.l = l; r.done = done;
        r.rdy = rdy; r.we = we; r.addr = addr; r.wd = wd; r.ps = ps;
        r.lc = lc; r.rc = rc; r.rd = rd; r.err = err;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h want 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input row_t r);
        chk("in_ready",   idx, 32'(bus.in_ready),   32'(r.rdy));
        chk("imem_we",    idx, 32'(bus.imem_we),    32'(r.we));
        chk("imem_addr",  idx, 32'(bus.imem_addr),  32'(r.addr));
        chk("imem_wdata", idx, 32'(bus.imem_wdata), 32'(r.wd));
        chk("proc_start", idx, 32'(proc_start),     32'(r.ps));
        chk("load_count", idx, 32'(load_count),     32'(r.lc));
        chk("run_cycles", idx, run_cycles,          r.rc);
        chk("run_done",   idx, 32'(run_done),       32'(r.rd));
        chk("error",      idx, 32'(error),          32'(r.err));
    endtask

    // Entered at a falling edge: drive, clock once, sample 1 time unit after the rising edge.
    task automatic apply(input int idx, input row_t r);
        bus.in_valid = r.v;
        bus.in_data  = r.d;
        bus.in_last  = r.l;
        proc_done    = r.done;
        @(posedge CLK);
        #1;
        check_outputs(idx, r);
        @(negedge CLK);
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        proc_done    = 1'b0;
    endtask

    // Assert reset between edges, check everything clears at once, release at a falling edge.
    task automatic pulse_reset(input int idx);
        reset = 1'b0;
        #1;
        check_outputs(idx, zero_row);
        drive_idle();
        @(negedge CLK);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        zero_row = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 3-word program; valid held through START/RUN must not be accepted.
        tbl.push_back(mk(1, 'h1A3, 0, 0, 1, 0, 0, 'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h1A3, 0, 0, 1, 1, 0, 'h1A3, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 'h0FF, 0, 0, 1, 1, 1, 'h0FF, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 'h101, 1, 0, 0, 1, 2, 'h101, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 'h055, 0, 0, 0, 0, 2, 'h101, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1, 'h055, 0, 0, 0, 0, 2, 'h101, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1, 'h055, 0, 0, 0, 0, 2, 'h101, 0, 3, 0, 0, 0));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk(1, 'h055, 0, 0, 0, 0, 2, 'h101, 0, 3, k, 0, 0));
        tbl.push_back(mk(0, 'h000, 0, 1, 1, 0, 2, 'h101, 0, 3, 5, 1, 0));
        tbl.push_back(mk(0, 'h000, 0, 1, 1, 0, 2, 'h101, 0, 3, 5, 1, 0));
        tbl.push_back(mk(0, 'h000, 0, 0, 1, 0, 2, 'h101, 0, 3, 5, 1, 0));
        tbl.push_back(mk(0, 'h000, 0, 1, 1, 0, 2, 'h101, 0, 3, 5, 1, 0));
        // 1-word reload from FINISH with proc_done stuck high through START.
        tbl.push_back(mk(1, 'h0AA, 1, 1, 0, 1, 0, 'h0AA, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 'h000, 0, 1, 0, 0, 0, 'h0AA, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 'h000, 0, 1, 0, 0, 0, 'h0AA, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 'h000, 0, 1, 0, 0, 0, 'h0AA, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 'h000, 0, 1, 1, 0, 0, 'h0AA, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 'h000, 0, 0, 1, 0, 0, 'h0AA, 0, 1, 1, 1, 0));
        // 1-word program that never finishes: timeout after 8 RUN cycles.
        tbl.push_back(mk(1, 'h1FF, 1, 0, 0, 1, 0, 'h1FF, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 'h000, 0, 0, 0, 0, 0, 'h1FF, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 'h000, 0, 0, 0, 0, 0, 'h1FF, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 'h000, 0, 0, 0, 0, 0, 'h1FF, 0, 1, 0, 0, 0));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(mk(0, 'h000, 0, 0, 0, 0, 0, 'h1FF, 0, 1, k, 0, 0));
        tbl.push_back(mk(0, 'h000, 0, 0, 0, 0, 0, 'h1FF, 0, 1, 8, 0, 1));
        tbl.push_back(mk(1, 'h123, 0, 1, 0, 0, 0, 'h1FF, 0, 1, 8, 0, 1));
        tbl.push_back(mk(1, 'h123, 0, 1, 0, 0, 0, 'h1FF, 0, 1, 8, 0, 1));

        // Reset state, held for two cycles with valid asserted.
        reset = 1'b0;
        drive_idle();
        bus.in_valid = 1'b1;
        repeat (2) @(negedge CLK);
        check_outputs(1000, zero_row);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(i, tbl[i]);

        // Overflow: 4 words without in_last fill capacity and trap in ERR.
        pulse_reset(2000);
        apply(3000, mk(0, 'h000, 0, 0, 1, 0, 0, 'h000, 0, 0, 0, 0, 0));
        apply(3001, mk(1, 'h011, 0, 0, 1, 1, 0, 'h011, 0, 1, 0, 0, 0));
        apply(3002, mk(1, 'h022, 0, 0, 1, 1, 1, 'h022, 0, 2, 0, 0, 0));
        apply(3003, mk(1, 'h033, 0, 0, 1, 1, 2, 'h033, 0, 3, 0, 0, 0));
        apply(3004, mk(1, 'h044, 0, 0, 0, 1, 3, 'h044, 0, 4, 0, 0, 1));
        for (int k = 0; k < 3; k++)
            apply(3005 + k, mk(1, 'h055, 1, 0, 0, 0, 3, 'h044, 0, 4, 0, 0, 1));

        // Reset mid-run: load one word, run 3 cycles, then abort.
        pulse_reset(4000);
        apply(4001, mk(0, 'h000, 0, 0, 1, 0, 0, 'h000, 0, 0, 0, 0, 0));
        apply(4002, mk(1, 'h042, 1, 0, 0, 1, 0, 'h042, 0, 1, 0, 0, 0));
        apply(4003, mk(0, 'h000, 0, 0, 0, 0, 0, 'h042, 1, 1, 0, 0, 0));
        apply(4004, mk(0, 'h000, 0, 0, 0, 0, 0, 'h042, 1, 1, 0, 0, 0));
        apply(4005, mk(0, 'h000, 0, 0, 0, 0, 0, 'h042, 0, 1, 0, 0, 0));
        for (int k = 1; k <= 3; k++)
            apply(4005 + k, mk(0, 'h000, 0, 0, 0, 0, 0, 'h042, 0, 1, k, 0, 0));
        pulse_reset(4100);
        apply(4101, mk(0, 'h000, 0, 0, 1, 0, 0, 'h000, 0, 0, 0, 0, 0));
        apply(4102, mk(1, 'h0C3, 1, 0, 0, 1, 0, 'h0C3, 0, 1, 0, 0, 0));
        apply(4103, mk(0, 'h000, 0, 0, 0, 0, 0, 'h0C3, 1, 1, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
